// File: rtl/mu0_pkg.sv
// Shared MU0 encodings: opcodes, ALU function, B-input select, control state and control vector.
package mu0_pkg;

  localparam int unsigned OPCODE_W = 4;
  localparam int unsigned ALUFN_W  = 2;
  localparam int unsigned BSEL_W   = 2;

  localparam logic [OPCODE_W-1:0] OP_LDA = 4'd0;
  localparam logic [OPCODE_W-1:0] OP_STA = 4'd1;
  localparam logic [OPCODE_W-1:0] OP_ADD = 4'd2;
  localparam logic [OPCODE_W-1:0] OP_SUB = 4'd3;
  localparam logic [OPCODE_W-1:0] OP_JMP = 4'd4;
  localparam logic [OPCODE_W-1:0] OP_JGE = 4'd5;
  localparam logic [OPCODE_W-1:0] OP_JNE = 4'd6;
  localparam logic [OPCODE_W-1:0] OP_STP = 4'd7;

  localparam logic [ALUFN_W-1:0] ALU_PASS_B = 2'b00;
  localparam logic [ALUFN_W-1:0] ALU_ADD    = 2'b01;
  localparam logic [ALUFN_W-1:0] ALU_SUB    = 2'b10;
  localparam logic [ALUFN_W-1:0] ALU_INC_B  = 2'b11;

  localparam logic [BSEL_W-1:0] BSEL_MEM = 2'b00;
  localparam logic [BSEL_W-1:0] BSEL_PC  = 2'b01;
  localparam logic [BSEL_W-1:0] BSEL_IR  = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_EXECUTE = 2'd1,
    ST_HALT    = 2'd2
  } state_e;

  typedef struct packed {
    logic               mem_rq;
    logic               rnw;
    logic               acc_oe;
    logic               addr_sel;
    logic [BSEL_W-1:0]  b_sel;
    logic [ALUFN_W-1:0] alu_fn;
    logic               acc_en;
    logic               pc_en;
    logic               ir_en;
    logic               halted;
  } ctrl_t;

endpackage

// File: rtl/mu0_decode.sv
// Combinational control-vector table: state, opcode, flags and memory ack to datapath controls.
module mu0_decode
  import mu0_pkg::*;
(
  input  state_e                state,
  input  logic [OPCODE_W-1:0]   opcode,
  input  logic                  acc_z,
  input  logic                  acc_n,
  input  logic                  mem_ack,
  output ctrl_t                 ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        // One ack both loads IR and writes PC+1 into PC.
        ctrl.mem_rq   = 1'b1;
        ctrl.rnw      = 1'b1;
        ctrl.addr_sel = 1'b0;
        ctrl.b_sel    = BSEL_PC;
        ctrl.alu_fn   = ALU_INC_B;
        ctrl.ir_en    = mem_ack;
        ctrl.pc_en    = mem_ack;
      end
      ST_EXECUTE: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b1;
            ctrl.addr_sel = 1'b1;
            ctrl.b_sel    = BSEL_MEM;
            ctrl.acc_en   = mem_ack;
            ctrl.alu_fn   = (opcode == OP_LDA) ? ALU_PASS_B :
                            (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
          end
          OP_STA: begin
            ctrl.mem_rq   = 1'b1;
            ctrl.rnw      = 1'b0;
            ctrl.addr_sel = 1'b1;
            ctrl.acc_oe   = 1'b1;
          end
          OP_JMP, OP_JGE, OP_JNE: begin
            ctrl.b_sel  = BSEL_IR;
            ctrl.alu_fn = ALU_PASS_B;
            ctrl.pc_en  = (opcode == OP_JMP) ? 1'b1 :
                          (opcode == OP_JGE) ? ~acc_n : ~acc_z;
          end
          default: ;
        endcase
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/mu0_control.sv
// MU0 fetch/execute sequencer; outputs are Mealy decodes of the current state, forced low in reset.
module mu0_control
  import mu0_pkg::*;
(
  input  logic                Clk,
  input  logic                Reset,
  input  logic [OPCODE_W-1:0] Opcode,
  input  logic                AccZ,
  input  logic                AccN,
  input  logic                MemAck,
  output logic                MemRq,
  output logic                RnW,
  output logic                AccOe,
  output logic                AddrSel,
  output logic [BSEL_W-1:0]   BSel,
  output logic [ALUFN_W-1:0]  AluFn,
  output logic                AccEn,
  output logic                PcEn,
  output logic                IrEn,
  output logic                Halted
);

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, ctrl_c;

  mu0_decode u_decode (
    .state   (state_q),
    .opcode  (Opcode),
    .acc_z   (AccZ),
    .acc_n   (AccN),
    .mem_ack (MemAck),
    .ctrl    (dec_ctrl)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH: if (MemAck) state_d = ST_EXECUTE;
      ST_EXECUTE: begin
        case (Opcode)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: if (MemAck) state_d = ST_FETCH;
          OP_STP:                         state_d = ST_HALT;
          default:                        state_d = ST_FETCH;
        endcase
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  // Reset dominates every output, abandoning any outstanding request.
  always_comb begin
    ctrl_c = dec_ctrl;
    if (Reset) ctrl_c = '0;
  end

  assign MemRq   = ctrl_c.mem_rq;
  assign RnW     = ctrl_c.rnw;
  assign AccOe   = ctrl_c.acc_oe;
  assign AddrSel = ctrl_c.addr_sel;
  assign BSel    = ctrl_c.b_sel;
  assign AluFn   = ctrl_c.alu_fn;
  assign AccEn   = ctrl_c.acc_en;
  assign PcEn    = ctrl_c.pc_en;
  assign IrEn    = ctrl_c.ir_en;
  assign Halted  = ctrl_c.halted;

endmodule

// File: tb/tb_mu0_control.sv
// Scoreboarded bench for mu0_control: directed test-plan sequence then randomized cycles vs. a behavioural model.
module tb_mu0_control;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [3:0] Opcode = 4'd0;
  logic       AccZ = 1'b0, AccN = 1'b0, MemAck = 1'b0;
  logic       MemRq, RnW, AccOe, AddrSel, AccEn, PcEn, IrEn, Halted;
  logic [1:0] BSel, AluFn;

  mu0_control dut (
    .Clk(Clk), .Reset(Reset), .Opcode(Opcode), .AccZ(AccZ), .AccN(AccN),
    .MemAck(MemAck), .MemRq(MemRq), .RnW(RnW), .AccOe(AccOe),
    .AddrSel(AddrSel), .BSel(BSel), .AluFn(AluFn), .AccEn(AccEn),
    .PcEn(PcEn), .IrEn(IrEn), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [11:0] exp;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;

  // Processor-level activity the model believes is in progress.
  localparam int FETCHING = 0, RUNNING = 1, STOPPED = 2;
  int activity = FETCHING;

  // Output vector: {MemRq,RnW,AccOe,AddrSel,BSel,AluFn,AccEn,PcEn,IrEn,Halted}
  function automatic logic [11:0] pack(logic rq, logic rnw, logic oe, logic as,
                                       logic [1:0] bs, logic [1:0] fn,
                                       logic ae, logic pe, logic ie, logic h);
    return {rq, rnw, oe, as, bs, fn, ae, pe, ie, h};
  endfunction

  function automatic logic [11:0] model_out(int act, logic r, logic a, logic [3:0] op,
                                            logic z, logic n);
    int op_i = int'(op);
    if (r) return 12'h000;
    if (act == STOPPED) return pack(0, 0, 0, 0, 2'd0, 2'd0, 0, 0, 0, 1);
    if (act == FETCHING) return pack(1, 1, 0, 0, 2'd1, 2'd3, 0, a, a, 0);
    if (op_i == 1) return pack(1, 0, 1, 1, 2'd0, 2'd0, 0, 0, 0, 0);
    if (op_i == 0 || op_i == 2 || op_i == 3)
      return pack(1, 1, 0, 1, 2'd0, (op_i == 0) ? 2'd0 : 2'(op_i - 1), a, 0, 0, 0);
    if (op_i >= 4 && op_i <= 6) begin
      logic take;
      take = (op_i == 4) || (op_i == 5 && !n) || (op_i == 6 && !z);
      return pack(0, 0, 0, 0, 2'd2, 2'd0, 0, take, 0, 0);
    end
    return 12'h000;
  endfunction

  function automatic int model_next(int act, logic r, logic a, logic [3:0] op);
    if (r) return FETCHING;
    if (act == STOPPED) return STOPPED;
    if (act == FETCHING) return a ? RUNNING : FETCHING;
    if (op < 4'd4) return a ? FETCHING : RUNNING;
    if (op == 4'd7) return STOPPED;
    return FETCHING;
  endfunction

  // Drive one cycle of inputs just after the edge and queue the expected outputs.
  task automatic cyc(input logic r, input logic a, input logic [3:0] op,
                     input logic z, input logic n);
    exp_t e;
    @(posedge Clk);
    #1;
    Reset = r; MemAck = a; Opcode = op; AccZ = z; AccN = n;
    cyc_no++;
    e.exp = model_out(activity, r, a, op, z, n);
    e.cyc = cyc_no;
    exp_q.push_back(e);
    activity = model_next(activity, r, a, op);
  endtask

  // Monitor: outputs are valid every cycle, compared mid-cycle.
  initial begin
    exp_t e;
    logic [11:0] act;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        act = {MemRq, RnW, AccOe, AddrSel, BSel, AluFn, AccEn, PcEn, IrEn, Halted};
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL ctrl_vec cycle %0d: got %03h want %03h", e.cyc, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [3:0] op;
    logic       r, a;
    // Reset then zero-wait fetch and LDA
    cyc(1, 0, 4'd0, 0, 0);
    cyc(1, 1, 4'd0, 0, 0);
    cyc(0, 1, 4'd0, 0, 0);
    cyc(0, 1, 4'd0, 0, 0);
    // Fetch with three wait states, ADD with one wait state
    repeat (3) cyc(0, 0, 4'd2, 0, 0);
    cyc(0, 1, 4'd2, 0, 0);
    cyc(0, 0, 4'd2, 0, 0);
    cyc(0, 1, 4'd2, 0, 0);
    // SUB and STA with one wait state each
    cyc(0, 1, 4'd3, 0, 0); cyc(0, 0, 4'd3, 0, 0); cyc(0, 1, 4'd3, 0, 0);
    cyc(0, 1, 4'd1, 0, 0); cyc(0, 0, 4'd1, 0, 0); cyc(0, 1, 4'd1, 0, 0);
    // Conditional jumps
    cyc(0, 1, 4'd5, 0, 1); cyc(0, 0, 4'd5, 0, 1);
    cyc(0, 1, 4'd5, 0, 0); cyc(0, 0, 4'd5, 0, 0);
    cyc(0, 1, 4'd6, 1, 0); cyc(0, 1, 4'd6, 1, 0);
    cyc(0, 1, 4'd6, 0, 0); cyc(0, 0, 4'd6, 0, 0);
    cyc(0, 1, 4'd9, 0, 0); cyc(0, 1, 4'd9, 0, 0);
    // STP, ten halted cycles with ack pulses, then reset
    cyc(0, 1, 4'd7, 0, 0); cyc(0, 0, 4'd7, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1'(i % 2), 4'd0, 0, 0);
    cyc(1, 0, 4'd0, 0, 0);
    // ADD abandoned by reset while waiting
    cyc(0, 1, 4'd2, 0, 0); cyc(0, 0, 4'd2, 0, 0);
    cyc(1, 1, 4'd2, 0, 0);
    cyc(0, 0, 4'd2, 0, 0); cyc(0, 1, 4'd2, 0, 0);

    // Randomized traffic; opcode only changes outside EXECUTE
    op = 4'd0;
    for (int i = 0; i < 3000; i++) begin
      if (activity != RUNNING) op = 4'($urandom_range(0, 15));
      r = (activity == STOPPED) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 199) == 0);
      a = ($urandom_range(0, 9) < 6);
      cyc(r, a, op, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge Clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
